fp_result_collector: RTL
========================

# fp_result_collector

Buffers and retires results from the reciprocal pipeline, which has a fixed latency and no backpressure. Captures each `{result, flags}` word into a FIFO and presents it on a ready/valid port. Issues credits upstream so the number of results in flight plus the number buffered never exceeds the FIFO depth. Accumulates retired exception flags into sticky fflags for the CSR path.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `issue`  in  1  pulse: upstream drove `valid_data_in` into the pipeline this cycle.
- `can_issue`  out  1  credit available; upstream may assert `issue` only when high.
- `pipe_valid`  in  1  pipeline `valid_data_out`.
- `pipe_out`  in  32  pipeline result.
- `pipe_invalid`, `pipe_dbz`, `pipe_ovf`, `pipe_unf`, `pipe_inx`  in  1 each  pipeline exception flags.
- `res_valid`  out  1  head entry valid.
- `res_ready`  in  1  consumer accepts the head entry.
- `res_data`  out  32  head result.
- `res_flags`  out  5  head flags, ordered {NV, DZ, OF, UF, NX} = {invalid, dbz, ovf, unf, inx}.
- `fflags_clr`  in  1  clear accrued flags.
- `fflags`  out  5  sticky OR of retired flags, same order.
- `occupancy`  out  $clog2(DEPTH)+1  FIFO entry count.
- `protocol_err`  out  1  sticky error indicator.

## Operation
- State:
  - FIFO memory, `DEPTH`×37 bits.
  - Write and read pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` (= `occupancy`).
  - `inflight` counter, $clog2(DEPTH)+2 bits, saturating at all-ones and at 0.
  - `fflags`, `protocol_err`.
- Push: occurs when `pipe_valid` is high.
  - Accepted if `count<DEPTH`, or if `count==DEPTH` and a pop happens the same cycle.
  - A push while full with no pop drops the word and sets `protocol_err`.
- Pop: `res_valid & res_ready`; the read pointer advances.
- `count` next value = `count` + push_accepted − pop.
- `inflight` next value = `inflight` + `issue` − `pipe_valid`.
  - `pipe_valid` with `inflight==0` sets `protocol_err`; the counter holds at 0, and the word is still pushed if space allows.
- `can_issue` = (`inflight` + `count`) < DEPTH.
  - Computed from registered state only; a same-cycle pop does not return a credit until the next cycle.
- `issue` while `can_issue==0`:
  - sets `protocol_err`;
  - is still counted in `inflight`.
- `fflags` next value = (`fflags_clr` ? 0 : `fflags`) | (pop ? `res_flags` : 0).
  - When clear and pop coincide, the popped flags survive.
- `protocol_err` is cleared only by reset.
- No state machine beyond the counters. FIFO is first-word-fall-through: `res_data`/`res_flags` come from memory at the read pointer and are held stable while `res_valid & ~res_ready`.

## Timing
- All outputs reset to 0 (`rst_n` low at a clock edge), except `can_issue`, which is 1 after reset.
- The reset cycle discards any concurrent `issue`, `pipe_valid`, or pop.
- Reset mid-operation empties the FIFO and zeroes `inflight`. Results still in the pipeline that arrive after reset count as stray arrivals and set `protocol_err`.
- Push-to-visible latency: a word pushed in cycle N into an empty FIFO gives `res_valid=1` in N+1. There is no same-cycle bypass.
- Pop in cycle N: the next entry, or `res_valid=0`, appears in N+1.
- `occupancy`, `fflags`, `protocol_err`, `can_issue`: all registered or derived from registered state, so each reflects cycle-N events in N+1.
- Sustained throughput is 1 push and 1 pop per cycle at any occupancy, including full and empty (an empty FIFO with a push reads out the following cycle).
- Pointer wrap: entry DEPTH−1 is followed by entry 0 with no bubble.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles, then release. Required: `can_issue=1`, `res_valid=0`, `occupancy=0`, `fflags=0`, `protocol_err=0`.
- Single result: `issue` at cycle 0; `pipe_valid` at cycle 13 with `pipe_out=0x3F000000` and `pipe_inx=0`. Required: `res_valid=1` at cycle 14 with `res_data=0x3F000000` and `res_flags=0`; with `res_ready=1`, `occupancy` returns to 0 at cycle 15.
- Credit limit (DEPTH=4, `res_ready=0`): issue 4 times on consecutive cycles. Required: `can_issue=0` after the fourth issue. Then return 4 results. Required: `occupancy=4`, `can_issue` stays 0, no `protocol_err`. After one pop, `can_issue=1` one cycle later.
- Full push+pop: FIFO full, `res_ready=1`, and `pipe_valid` in the same cycle. Required: `occupancy` stays 4, the new word lands at the wrapped tail, and retire order is preserved.
- Flags: retire words with flags 5'b01000, then 5'b00011 → `fflags=5'b01011`. Then assert `fflags_clr` together with a pop carrying 5'b00100. Required: `fflags=5'b00100`.
- Errors: `pipe_valid` with `inflight=0`, and `issue` with `can_issue=0`. Required: `protocol_err=1` the following cycle, held until reset; a push into a full FIFO with no pop is dropped and `occupancy` is unchanged.

Source files
------------

// File: rtl/fp_result_collector.sv
// fp_result_collector: FWFT result FIFO behind the fixed-latency reciprocal pipeline,
// with upstream credit control, sticky fflags accrual and a sticky protocol error flag.
module fp_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue,
    output logic                     can_issue,
    input  logic                     pipe_valid,
    input  logic [31:0]              pipe_out,
    input  logic                     pipe_invalid,
    input  logic                     pipe_dbz,
    input  logic                     pipe_ovf,
    input  logic                     pipe_unf,
    input  logic                     pipe_inx,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [4:0]               res_flags,
    input  logic                     fflags_clr,
    output logic [4:0]               fflags,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = AW + 2;

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] inflight, inflight_nxt;
    logic          pop, push, full, stray, drop, bad_issue;

    assign occupancy = count;
    assign res_valid = count != '0;
    assign {res_data, res_flags} = mem[rd_ptr];
    assign pop       = res_valid & res_ready;
    assign full      = count == CW'(DEPTH);
    assign push      = pipe_valid & (~full | pop);
    assign drop      = pipe_valid & full & ~pop;
    assign stray     = pipe_valid & (inflight == '0);
    assign can_issue = ({1'b0, inflight} + (IW+1)'(count)) < (IW+1)'(DEPTH);
    assign bad_issue = issue & ~can_issue;

    // inflight saturates at both ends so stray arrivals cannot wrap it
    always_comb
        inflight_nxt = (issue & ~pipe_valid & ~&inflight) ? inflight + IW'(1) :
                       (~issue & pipe_valid & |inflight)   ? inflight - IW'(1) : inflight;

    always_ff @(posedge clk)
        if (rst_n && push)
            mem[wr_ptr] <= {pipe_out, pipe_invalid, pipe_dbz, pipe_ovf, pipe_unf, pipe_inx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            inflight     <= '0;
            fflags       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight_nxt;
            fflags   <= (fflags_clr ? 5'b0 : fflags) | (pop ? res_flags : 5'b0);
            if (stray | drop | bad_issue)
                protocol_err <= 1'b1;
        end
    end
endmodule
